// File: rtl/neuron_accumulator.sv
// Neuron pre-activation accumulator: sums NUM_INPUTS sign-magnitude products
// in a wide two's complement register, adds the bias, then saturates back to
// sign-magnitude. One result per group; groups never overlap.
module neuron_accumulator #(
  parameter int N               = 16,
  parameter int FRACTIONAL_BITS = 13,
  parameter int NUM_INPUTS      = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic [N-1:0] bias,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  input  logic         in_ovf,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sat,
  output logic         out_ovf
);

  // Count register also serves as the "first product" detector (count == 0).
  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  // One extra bit beyond the worst-case sum of NUM_INPUTS products plus bias,
  // so neither the accumulation nor the bias add can wrap.
  localparam int ACC_W = N + CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);
  localparam logic [ACC_W-1:0] MAG_MAX  = {{(ACC_W - N + 1){1'b0}}, {(N - 1){1'b1}}};

  // Fraction position never matters here: products and bias share one format.
  if (NUM_INPUTS < 1 || FRACTIONAL_BITS < 0 || FRACTIONAL_BITS > N - 1) begin : g_param_check
    $error("neuron_accumulator: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    S_ACC,
    S_BIAS,
    S_OUT
  } state_t;

  state_t                    state_q;
  logic [CNT_W-1:0]          count_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic                      ovf_sticky_q;
  logic                      out_valid_q;
  logic [N-1:0]              out_data_q;
  logic                      out_sat_q;
  logic                      out_ovf_q;

  logic signed [ACC_W-1:0]   prod_tc;
  logic signed [ACC_W-1:0]   bias_tc;
  logic signed [ACC_W-1:0]   acc_d;
  logic                      ovf_sticky_d;
  logic signed [ACC_W-1:0]   sum_d;
  logic [ACC_W-1:0]          sum_abs_d;
  logic                      res_sat_d;
  logic [N-1:0]              res_data_d;

  // Negative zero maps to 0 because -0 == 0 in two's complement.
  function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic [N-1:0] v);
    logic signed [ACC_W-1:0] mag;
    mag = $signed({{(ACC_W - N + 1){1'b0}}, v[N-2:0]});
    return v[N-1] ? -mag : mag;
  endfunction

  // Next accumulator value, bias sum and saturated sign-magnitude result.
  always_comb begin
    prod_tc      = sm_to_tc(in_data);
    bias_tc      = sm_to_tc(bias);
    acc_d        = (count_q == '0) ? prod_tc : (acc_q + prod_tc);
    ovf_sticky_d = (count_q == '0) ? in_ovf : (ovf_sticky_q | in_ovf);
    sum_d        = acc_q + bias_tc;
    sum_abs_d    = sum_d[ACC_W-1] ? ACC_W'(-sum_d) : ACC_W'(sum_d);
    res_sat_d    = (sum_abs_d > MAG_MAX);
    // A zero sum has a clear sign bit, so no negative zero can be produced.
    res_data_d   = res_sat_d ? {sum_d[ACC_W-1], {(N - 1){1'b1}}}
                             : {sum_d[ACC_W-1], sum_abs_d[N-2:0]};
  end

  // Group sequencer: accumulate, add bias for one cycle, then hold the result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_ACC;
      count_q      <= '0;
      acc_q        <= '0;
      ovf_sticky_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sat_q    <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else if (clear) begin
      state_q      <= S_ACC;
      count_q      <= '0;
      ovf_sticky_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sat_q    <= 1'b0;
      out_ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_ACC: begin
          if (in_valid) begin
            acc_q        <= acc_d;
            ovf_sticky_q <= ovf_sticky_d;
            if (count_q == LAST_CNT) begin
              count_q <= '0;
              state_q <= S_BIAS;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        S_BIAS: begin
          out_data_q  <= res_data_d;
          out_sat_q   <= res_sat_d;
          out_ovf_q   <= ovf_sticky_q;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_ACC;
          end
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator with hand-computed Q2.13 results.
module tb_neuron_accumulator;

  logic        clk;
  logic        rstn;
  logic        clear;
  logic [15:0] bias;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ovf;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] prods [8];
  logic        ovfs  [8];

  neuron_accumulator #(
    .N(16),
    .FRACTIONAL_BITS(13),
    .NUM_INPUTS(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .clear(clear),
    .bias(bias),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ovf(in_ovf),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sat(out_sat),
    .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 8; i++) begin
      prods[i] = v;
      ovfs[i]  = 1'b0;
    end
  endtask

  task automatic set_nominal();
    for (int i = 0; i < 4; i++) prods[i] = 16'h1000;
    prods[4] = 16'h9000;
    prods[5] = 16'h9000;
    prods[6] = 16'h0800;
    prods[7] = 16'h0800;
    for (int i = 0; i < 8; i++) ovfs[i] = 1'b0;
    bias = 16'h2000;
  endtask

  // Presents prods[0..n-1]; returns #1 after the edge of the last transfer.
  task automatic send_products(input int n);
    for (int i = 0; i < n; i++) begin
      int waited;
      in_valid = 1'b1;
      in_data  = prods[i];
      in_ovf   = ovfs[i];
      waited   = 0;
      while (!in_ready && waited < 40) begin
        @(posedge clk); #1;
        waited++;
      end
      if (waited == 40) check("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_ovf   = 1'b0;
    in_data  = 16'h0000;
  endtask

  // Called #1 after the last transfer edge t: BIAS at t, result at t+1,
  // handshake at t+2 when out_ready is high.
  task automatic expect_result(input string tag, input logic [15:0] ed,
                               input logic es, input logic eo);
    check({tag, "_bias_valid"}, out_valid, 0);
    check({tag, "_bias_ready"}, in_ready, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_sat"}, out_sat, es);
    check({tag, "_ovf"}, out_ovf, eo);
    $display("group %s: data=%04h sat=%0d ovf=%0d", tag, out_data, out_sat, out_ovf);
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_done_valid"}, out_valid, 0);
      check({tag, "_done_ready"}, in_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; clear = 1'b0; bias = '0; in_valid = 1'b0;
    in_data = '0; in_ovf = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 16'h0000);
    check("rst_sat", out_sat, 0);
    check("rst_ovf", out_ovf, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", in_ready, 1);

    // 2.0 - 1.0 + 0.5 + bias 1.0 = 2.5
    set_nominal();
    send_products(8);
    expect_result("nominal", 16'h5000, 0, 0);

    fill(16'hA000); bias = 16'h0000;
    send_products(8);
    expect_result("sat_neg", 16'hFFFF, 1, 0);

    fill(16'h2000); bias = 16'h0000;
    send_products(8);
    expect_result("sat_pos", 16'h7FFF, 1, 0);

    fill(16'h8000); bias = 16'h8000;
    send_products(8);
    expect_result("neg_zero", 16'h0000, 0, 0);

    // Largest representable magnitude: not saturated; one LSB more saturates.
    fill(16'h0000); prods[0] = 16'h7FFF; bias = 16'h0000;
    send_products(8);
    expect_result("max_exact", 16'h7FFF, 0, 0);
    fill(16'h0000); prods[0] = 16'h7FFF; bias = 16'h0001;
    send_products(8);
    expect_result("max_plus1", 16'h7FFF, 1, 0);

    // Negative result: 8 x -0.125 = -1.0
    fill(16'h8400); bias = 16'h0000;
    send_products(8);
    expect_result("negative", 16'hA000, 0, 0);

    // Exact cancellation gives positive zero
    fill(16'h1000); for (int i = 4; i < 8; i++) prods[i] = 16'h9000; bias = 16'h0000;
    send_products(8);
    expect_result("cancel", 16'h0000, 0, 0);

    // Backpressure: result held, no product consumed while stalled
    out_ready = 1'b0;
    set_nominal();
    send_products(8);
    expect_result("bp", 16'h5000, 0, 0);
    in_valid = 1'b1; in_data = 16'h1000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 16'h5000);
      check("bp_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    set_nominal();
    send_products(8);
    expect_result("after_bp", 16'h5000, 0, 0);

    // Overflow flag is sticky within a group only
    set_nominal(); ovfs[1] = 1'b1;
    send_products(8);
    expect_result("ovf_set", 16'h5000, 0, 1);
    set_nominal();
    send_products(8);
    expect_result("ovf_clr", 16'h5000, 0, 0);

    // Clear after 3 products (one flagged); product presented with clear dropped
    set_nominal(); ovfs[2] = 1'b1;
    send_products(3);
    clear = 1'b1; in_valid = 1'b1; in_data = 16'h7000;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clear_ready", in_ready, 1);
    check("clear_valid", out_valid, 0);
    fill(16'h0400); bias = 16'h0000;
    send_products(8);
    expect_result("post_clear", 16'h2000, 0, 0);

    // Clear while holding a saturated result
    out_ready = 1'b0;
    fill(16'h2000); bias = 16'h0000;
    send_products(8);
    expect_result("clr_out", 16'h7FFF, 1, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_out_valid", out_valid, 0);
    check("clr_out_sat", out_sat, 0);
    check("clr_out_ready", in_ready, 1);
    out_ready = 1'b1;
    set_nominal();
    send_products(8);
    expect_result("after_clr_out", 16'h5000, 0, 0);

    // Asynchronous reset while a result is pending
    out_ready = 1'b0;
    set_nominal();
    send_products(8);
    expect_result("pre_reset", 16'h5000, 0, 0);
    #2 rstn = 1'b0;
    #1;
    check("areset_valid", out_valid, 0);
    check("areset_data", out_data, 16'h0000);
    check("areset_ready", in_ready, 1);
    @(posedge clk); #1;
    rstn = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    set_nominal();
    send_products(8);
    expect_result("post_reset", 16'h5000, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
